// File: rtl/trace_pkg.sv
// Shared types for the commit-trace encoder:
// header layout, FSM states, queued entry, field sizes.
package trace_pkg;

  localparam int HDR_I = 0;
  localparam int HDR_W = 1;
  localparam int HDR_R = 2;
  localparam int HDR_L = 3;

  localparam int PC_BYTES   = 4;
  localparam int INST_BYTES = 4;
  localparam int RD_BYTES   = 1;
  localparam int DATA_BYTES = 4;
  localparam int TGT_BYTES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PC,
    S_INST,
    S_RD,
    S_DATA,
    S_TGT
  } state_t;

  typedef struct packed {
    logic        i;
    logic        w;
    logic        r;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] rd_data;
    logic [31:0] pc_x;
  } entry_t;

  function automatic logic [7:0] header(
    entry_t e,
    logic   l
  );
    logic [7:0] h;
    h        = '0;
    h[HDR_I] = e.i;
    h[HDR_W] = e.w;
    h[HDR_R] = e.r;
    h[HDR_L] = l;
    return h;
  endfunction

  function automatic logic [1:0] last_idx(
    state_t s
  );
    case (s)
      S_PC:    return 2'(PC_BYTES - 1);
      S_INST:  return 2'(INST_BYTES - 1);
      S_RD:    return 2'(RD_BYTES - 1);
      S_DATA:  return 2'(DATA_BYTES - 1);
      S_TGT:   return 2'(TGT_BYTES - 1);
      default: return 2'd0;
    endcase
  endfunction

  // S_IDLE as a result means the record is complete
  function automatic state_t next_field(
    state_t s,
    entry_t e
  );
    case (s)
      S_HDR:
        return e.i ? S_PC :
               e.w ? S_RD :
               e.r ? S_TGT : S_IDLE;
      S_PC:   return S_INST;
      S_INST:
        return e.w ? S_RD :
               e.r ? S_TGT : S_IDLE;
      S_RD:   return S_DATA;
      S_DATA: return e.r ? S_TGT : S_IDLE;
      default: return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/trace_if.sv
// Byte stream toward the trace sink.
// Valid/ready handshake, one byte per accept.
interface trace_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with full/empty flags.
// A push while full is accepted when a pop frees a slot.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign empty = wptr == rptr;
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/trace_encoder.sv
// Commit-trace transmitter: queues cpu events and
// serializes them as header + little-endian fields.
module trace_encoder #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             inst_v,
  input  logic [31:0]      pc,
  input  logic [31:0]      inst,
  input  logic             rd_v,
  input  logic [4:0]       rd,
  input  logic [31:0]      rd_data,
  input  logic             pc_v,
  input  logic [31:0]      pc_x,
  trace_if.master          tx,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);
  import trace_pkg::*;

  entry_t     ev;
  entry_t     head;
  entry_t     cur;
  logic       cur_l;
  logic       lost;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       drop;
  logic       fire;
  logic       last;
  state_t     state;
  state_t     state_n;
  logic [1:0] idx;
  logic [1:0] idx_n;
  logic [7:0] tx_byte;

  always_comb begin
    ev.i       = inst_v;
    ev.w       = rd_v & (rd != 5'd0);
    ev.r       = pc_v;
    ev.rd      = rd;
    ev.pc      = pc;
    ev.inst    = inst;
    ev.rd_data = rd_data;
    ev.pc_x    = pc_x;
  end

  assign push = enable & (ev.i | ev.w | ev.r);
  assign drop = push & full & ~pop;

  trace_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (ev),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign tx.tx_valid = state != S_IDLE;
  assign tx.tx_data  = tx_byte;
  assign fire        = tx.tx_valid & tx.tx_ready;
  assign last        = idx == last_idx(state);
  assign busy        = ~empty | (state != S_IDLE);

  always_comb begin
    state_n = state;
    idx_n   = idx;
    pop     = 1'b0;
    tx_byte = '0;
    unique case (state)
      S_HDR:  tx_byte = header(cur, cur_l);
      S_PC:   tx_byte = cur.pc[{idx, 3'b000} +: 8];
      S_INST: tx_byte = cur.inst[{idx, 3'b000} +: 8];
      S_RD:   tx_byte = {3'b000, cur.rd};
      S_DATA: tx_byte = cur.rd_data[{idx, 3'b000} +: 8];
      S_TGT:  tx_byte = cur.pc_x[{idx, 3'b000} +: 8];
      default: tx_byte = '0;
    endcase
    if (state == S_IDLE) begin
      if (!empty) begin
        pop     = 1'b1;
        state_n = S_HDR;
      end
    end else if (fire) begin
      if (last) begin
        idx_n   = '0;
        state_n = next_field(state, cur);
        // chain straight into the next record
        if (state_n == S_IDLE && !empty) begin
          pop     = 1'b1;
          state_n = S_HDR;
        end
      end else begin
        idx_n = idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      idx   <= '0;
      cur   <= '0;
      cur_l <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (pop) begin
        cur   <= head;
        cur_l <= lost;
      end
    end
  end

  // a drop in the load cycle keeps the flag for the next header
  always_ff @(posedge clk) begin
    if (!reset) begin
      lost     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)     lost <= 1'b1;
      else if (pop) lost <= 1'b0;
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_trace_encoder.sv
// Bench for trace_encoder: queue-level model checked
// every cycle plus literal records from hand-built streams.
module tb_trace_encoder;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             inst_v = 1'b0;
  logic [31:0]      pc = '0;
  logic [31:0]      inst = '0;
  logic             rd_v = 1'b0;
  logic [4:0]       rd = '0;
  logic [31:0]      rd_data = '0;
  logic             pc_v = 1'b0;
  logic [31:0]      pc_x = '0;
  logic [CNT_W-1:0] drop_cnt;
  logic             busy;

  trace_if bus ();

  trace_encoder #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .inst_v   (inst_v),
    .pc       (pc),
    .inst     (inst),
    .rd_v     (rd_v),
    .rd       (rd),
    .rd_data  (rd_data),
    .pc_v     (pc_v),
    .pc_x     (pc_x),
    .tx       (bus),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        i;
    bit        w;
    bit        r;
    bit [4:0]  rd;
    bit [31:0] pc;
    bit [31:0] inst;
    bit [31:0] data;
    bit [31:0] pcx;
  } ev_t;

  int n_chk = 0;
  int n_pass = 0;

  ev_t         mq [$];
  logic [7:0]  mb [$];
  logic [7:0]  rx [$];
  logic [7:0]  ref2 [$];
  bit          mlost = 0;
  int          mdrop = 0;
  bit          model_on = 0;
  bit          rand_ready = 0;
  logic        rdy_fixed = 1'b1;

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h",
                  name, act, exp);
  endtask

  function automatic void emit(ev_t e, bit l);
    mb.push_back({4'b0, l, e.r, e.w, e.i});
    if (e.i) begin
      for (int k = 0; k < 4; k++)
        mb.push_back(e.pc[8*k +: 8]);
      for (int k = 0; k < 4; k++)
        mb.push_back(e.inst[8*k +: 8]);
    end
    if (e.w) begin
      mb.push_back({3'b0, e.rd});
      for (int k = 0; k < 4; k++)
        mb.push_back(e.data[8*k +: 8]);
    end
    if (e.r)
      for (int k = 0; k < 4; k++)
        mb.push_back(e.pcx[8*k +: 8]);
  endfunction

  // reference: a queue of events and a queue of bytes in flight
  always @(posedge clk) begin : model
    ev_t e;
    bit  pop;
    bit  req;
    bit  drop;
    if (!reset) begin
      mq.delete();
      mb.delete();
      mlost    = 0;
      mdrop    = 0;
      model_on = 1;
    end else begin
      if (mb.size() != 0 && bus.tx_ready)
        void'(mb.pop_front());
      pop    = (mb.size() == 0) && (mq.size() != 0);
      e.i    = inst_v;
      e.w    = rd_v && (rd != 5'd0);
      e.r    = pc_v;
      e.rd   = rd;
      e.pc   = pc;
      e.inst = inst;
      e.data = rd_data;
      e.pcx  = pc_x;
      req    = enable && (e.i || e.w || e.r);
      drop   = 0;
      if (pop) emit(mq.pop_front(), mlost);
      if (req) begin
        if (mq.size() < DEPTH) mq.push_back(e);
        else drop = 1;
      end
      if (drop) begin
        mlost = 1;
        if (mdrop < (1 << CNT_W) - 1) mdrop++;
      end else if (pop) begin
        mlost = 0;
      end
    end
  end

  always @(posedge clk)
    if (reset && bus.tx_valid && bus.tx_ready)
      rx.push_back(bus.tx_data);

  always @(negedge clk) begin
    #1;
    bus.tx_ready = rand_ready ?
      1'($urandom_range(0, 1)) : rdy_fixed;
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("tx_valid", bus.tx_valid, mb.size() != 0);
      if (mb.size() != 0)
        check("tx_data", bus.tx_data, mb[0]);
      check("busy", busy,
            mq.size() != 0 || mb.size() != 0);
      check("drop_cnt", drop_cnt, mdrop);
    end
  end

  task automatic put_ev(
    input bit        i,
    input bit        w,
    input bit        r,
    input bit [4:0]  d,
    input bit [31:0] p,
    input bit [31:0] n,
    input bit [31:0] v,
    input bit [31:0] t
  );
    inst_v  = i;
    rd_v    = w;
    pc_v    = r;
    rd      = d;
    pc      = p;
    inst    = n;
    rd_data = v;
    pc_x    = t;
    @(negedge clk);
    inst_v = 0;
    rd_v   = 0;
    pc_v   = 0;
  endtask

  task automatic wait_idle(input int lim);
    int k;
    k = 0;
    while (k < lim && (mb.size() != 0 || mq.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check("drain_timeout", k < lim, 1'b1);
  endtask

  logic [7:0] e1 [9] = '{
    8'h01, 8'h00, 8'h00, 8'h00, 8'h80,
    8'h93, 8'h00, 8'h10, 8'h00
  };
  logic [7:0] e2 [18] = '{
    8'h07, 8'h04, 8'h00, 8'h00, 8'h80,
    8'h13, 8'h00, 8'h00, 8'h00, 8'h05,
    8'hEF, 8'hBE, 8'hAD, 8'hDE,
    8'h10, 8'h00, 8'h00, 8'h80
  };

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.tx_valid, 1'b0);
    check("rst_data", bus.tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_drop", drop_cnt, 0);
    reset  = 1'b1;
    enable = 1'b1;
    @(negedge clk);

    // single issue, latency and byte order
    rx.delete();
    put_ev(1, 0, 0, 0, 32'h80000000, 32'h00100093, 0, 0);
    check("lat_capture", bus.tx_valid, 1'b0);
    @(negedge clk);
    check("lat_hdr_valid", bus.tx_valid, 1'b1);
    check("lat_hdr_data", bus.tx_data, 8'h01);
    wait_idle(100);
    check("t1_len", rx.size(), 9);
    for (int b = 0; b < 9; b++)
      check($sformatf("t1_b%0d", b), rx[b], e1[b]);
    check("t1_idle", bus.tx_valid, 1'b0);

    // combined event
    rx.delete();
    put_ev(1, 1, 1, 5'd5, 32'h80000004, 32'h00000013,
           32'hDEADBEEF, 32'h80000010);
    wait_idle(100);
    check("t2_len", rx.size(), 18);
    for (int b = 0; b < 18; b++)
      check($sformatf("t2_b%0d", b), rx[b], e2[b]);
    ref2 = rx;

    // rd=0 writeback and disabled capture make no record
    rx.delete();
    put_ev(0, 1, 0, 5'd0, 0, 0, 32'h12345678, 0);
    enable = 1'b0;
    put_ev(1, 0, 1, 0, 32'h40, 32'h13, 0, 32'h80);
    enable = 1'b1;
    repeat (3) begin
      check("noev_busy", busy, 1'b0);
      @(negedge clk);
    end
    check("noev_len", rx.size(), 0);

    // backpressure
    rx.delete();
    rand_ready = 1;
    put_ev(1, 1, 1, 5'd5, 32'h80000004, 32'h00000013,
           32'hDEADBEEF, 32'h80000010);
    wait_idle(300);
    rand_ready = 0;
    check("bp_len", rx.size(), ref2.size());
    for (int b = 0; b < 18; b++)
      check($sformatf("bp_b%0d", b), rx[b], ref2[b]);

    // overflow
    rdy_fixed = 1'b0;
    rx.delete();
    @(negedge clk);
    put_ev(1, 0, 0, 0, 32'h1000, 32'h13, 0, 0);
    repeat (2) @(negedge clk);
    for (int b = 0; b < DEPTH + 3; b++) begin
      inst_v = 1;
      pc     = 32'h2000 + 32'(4 * b);
      inst   = 32'h13;
      @(negedge clk);
    end
    inst_v = 0;
    check("ovf_drop", drop_cnt, 3);
    check("ovf_hdr0", bus.tx_data, 8'h01);
    rdy_fixed = 1'b1;
    wait_idle(400);
    check("ovf_len", rx.size(), 9 * (DEPTH + 1));
    check("ovf_h0", rx[0], 8'h01);
    check("ovf_h1_lost", rx[9], 8'h09);
    check("ovf_h2", rx[18], 8'h01);
    check("ovf_drop_hold", drop_cnt, 3);

    // reset mid-record
    rx.delete();
    put_ev(1, 1, 1, 5'd7, 32'h3000, 32'h13, 32'h55, 32'h4000);
    put_ev(1, 0, 0, 0, 32'h3004, 32'h13, 0, 0);
    k = 0;
    while (rx.size() < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mid_wait", rx.size(), 3);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mid_valid", bus.tx_valid, 1'b0);
    check("mid_drop", drop_cnt, 0);
    check("mid_busy", busy, 1'b0);
    repeat (20) @(negedge clk);
    check("mid_residual", rx.size(), 3);

    // random traffic with random sink stalls
    rand_ready = 1;
    for (int c = 0; c < 3000; c++) begin
      reset   = (c != 1500);
      enable  = $urandom_range(0, 7) != 0;
      inst_v  = $urandom_range(0, 2) == 0;
      rd_v    = $urandom_range(0, 3) == 0;
      rd      = ($urandom_range(0, 3) == 0) ? 5'd0
                : 5'($urandom_range(1, 31));
      pc_v    = $urandom_range(0, 4) == 0;
      pc      = $urandom;
      inst    = $urandom;
      rd_data = $urandom;
      pc_x    = $urandom;
      @(negedge clk);
    end
    reset  = 1'b1;
    inst_v = 0;
    rd_v   = 0;
    pc_v   = 0;
    wait_idle(2000);
    rand_ready = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/trace_encoder.md
Name: trace_encoder

Overview:
- Transmitter side of the commit-trace byte protocol: captures per-cycle issue, writeback and redirect events from the cpu and emits them as a serialized byte stream.
- The stream uses a valid/ready handshake toward a trace sink, which is either a host link or the simulation trace receiver.
- Events are buffered in a small FIFO so the core never stalls.
- On overflow, events are dropped, counted, and flagged in the next record sent.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- enable  input  1  capture enable; 0 = ignore new events, drain the FIFO normally
- inst_v  input  1  instruction issued this cycle
- pc  input  32  pc of the issued instruction
- inst  input  32  encoding of the issued instruction
- rd_v  input  1  register writeback this cycle
- rd  input  5  writeback register index
- rd_data  input  32  writeback value
- pc_v  input  1  pc redirect (taken branch/jump) this cycle
- pc_x  input  32  redirect target
- tx_data  output  8  stream byte
- tx_valid  output  1  tx_data valid
- tx_ready  input  1  sink accepts the byte when tx_valid & tx_ready at posedge
- drop_cnt  output  CNT_W  number of dropped events, saturating
- busy  output  1  FIFO non-empty or serializer active

Behaviour:
- Reset (reset==0 at posedge):
  - FIFO emptied, FSM to IDLE, lost flag cleared.
  - drop_cnt=0, tx_valid=0, tx_data=0, busy=0.
  - Reset mid-record abandons the record; no partial bytes are emitted after reset.
- Capture:
  - Per cycle, I=inst_v, W=rd_v&(rd!=0), R=pc_v.
  - If enable & (I|W|R), one entry {I,W,R,rd,pc,inst,rd_data,pc_x} is formed.
  - A cycle with no flags set produces no entry.
- FIFO push:
  - If the FIFO is not full, the entry is pushed at posedge.
  - If full, the entry is dropped, drop_cnt increments (saturates at all-ones) and the lost flag is set.
  - A push in the same cycle as a pop on a full FIFO is allowed; the pop frees the slot, so no drop occurs.
  - Flow-through: an entry pushed into an empty FIFO is available to the FSM the next cycle.
- Record format (multi-byte fields little-endian):
  - Header byte: [0]=I, [1]=W, [2]=R, [3]=L, [7:4]=0.
  - If I: pc (4 bytes), then inst (4 bytes).
  - If W: {3'b0,rd} (1 byte), then rd_data (4 bytes).
  - If R: pc_x (4 bytes).
  - Record length ranges from 1+4 to 18 bytes.
- L bit:
  - L is the lost flag sampled when the header is loaded.
  - The lost flag clears when that header is loaded, unless a drop occurs in the same cycle, in which case it stays set.
- FSM states: IDLE, HDR, PC, INST, RD, DATA, TGT. A 2-bit byte index is used in PC/INST/DATA/TGT.
  - IDLE: when the FIFO is non-empty, pop the head into the output register and go to HDR.
  - Each state holds tx_valid=1 and a stable tx_data until the handshake completes.
  - A multi-byte state advances after byte index 3.
  - Next state after each field is the next present field in the order I, W, R. After the last field, go to IDLE.
  - The last-byte handshake may pop the next entry in the same cycle (go straight to HDR), giving back-to-back records with no bubble.
- Output timing:
  - tx_valid must not depend combinationally on tx_ready.
  - Once tx_valid is asserted, tx_data is stable until accepted.
  - Minimum latency from event to header byte on tx_data is 2 cycles: capture, then pop.
- busy = FIFO non-empty | (state != IDLE).
- enable deasserted mid-record: the record in flight and the queued entries still drain.

Decomposition:
- Package trace_pkg holds:
  - header bit positions;
  - the fsm state enum;
  - the packed entry struct type;
  - record field byte counts.
- One sub-module, trace_fifo: parameterized synchronous FIFO with full/empty, push/pop and same-cycle push+pop on full.
- The encoder FSM and drop logic live in trace_encoder.

Test Plan:
- Single issue, tx_ready=1. Stimulus: inst_v with pc=0x80000000, inst=0x00100093. Required stream: 01 00 00 00 80 93 00 10 00, then tx_valid=0.
- Combined event. Stimulus: inst_v + rd_v (rd=5, rd_data=0xDEADBEEF) + pc_v (pc_x=0x80000010). Required: a 18-byte record with header 07, rd byte 05, data bytes EF BE AD DE, target bytes 10 00 00 80.
- rd_v with rd=0 and no other flags -> no record. Stimulus: rd_v only, rd=0. Required: busy stays 0.
- Overflow. Stimulus: tx_ready=0, then DEPTH+3 consecutive issue cycles. Required: drop_cnt=3 and the FIFO holds DEPTH entries. Then raise tx_ready: the first record header is 01, and the first header loaded after the drops has L=1 (value 09).
- Backpressure. Stimulus: toggle tx_ready randomly during a record. Required: tx_data is stable while tx_valid & !tx_ready, and the byte sequence is identical to the tx_ready=1 case.
- Reset mid-record. Stimulus: assert reset after 3 bytes. Required: next cycle tx_valid=0, drop_cnt=0, busy=0, and no residual bytes appear afterward.
